// File: rtl/mem_arbiter_if.sv
// Bundle of fetch, load/store and memory-side signals around mem_arbiter.
// slave = arbiter view; master = view of the core/memory environment that drives it.
interface mem_arbiter_if;
    logic        i_req;
    logic [29:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        i_err;

    logic        d_req;
    logic [3:0]  d_we;
    logic [29:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;

    logic        mem_valid;
    logic [29:0] mem_addr;
    logic [3:0]  mem_we;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
        output i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
               mem_valid, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
        input  i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
               mem_valid, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin share of one word-addressed memory port between fetch (I) and load/store (D).
// Latency: req->ack 2 cycles with zero-wait memory, +1 per wait state; one access in flight.
// Backpressure: requesters hold req until ack; mem_valid held until mem_ready (MEM_ARB_TIMEOUT_EN adds abort after TIMEOUT).
module mem_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         resetn,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state;
    logic        last_grant_d;
    logic        grant_d;
    logic        timed_out;
    logic        access_done;
    logic [31:0] rsp_word;

`ifdef MEM_ARB_TIMEOUT_EN
    logic [7:0] wait_cnt;
    // A memory answer in the expiry cycle still wins over the abort.
    assign timed_out = !bus.mem_ready && (wait_cnt == 8'(TIMEOUT - 1));
`else
    logic [7:0] unused_timeout;
    assign unused_timeout = 8'(TIMEOUT);
    assign timed_out      = 1'b0;
    assign bus.i_err      = 1'b0;
    assign bus.d_err      = 1'b0;
`endif

    assign access_done = bus.mem_ready || timed_out;
    assign rsp_word    = timed_out ? 32'h0 : bus.mem_rdata;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            last_grant_d  <= 1'b0;
            grant_d       <= 1'b0;
            bus.mem_valid <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_we    <= '0;
            bus.mem_wdata <= '0;
            bus.i_ack     <= 1'b0;
            bus.d_ack     <= 1'b0;
            bus.i_rdata   <= '0;
            bus.d_rdata   <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            wait_cnt      <= '0;
            bus.i_err     <= 1'b0;
            bus.d_err     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // On conflict the side not served last wins; last_grant resets to I so D wins first.
                    if (bus.d_req && (!bus.i_req || !last_grant_d)) begin
                        grant_d       <= 1'b1;
                        last_grant_d  <= 1'b1;
                        bus.mem_addr  <= bus.d_addr;
                        bus.mem_we    <= bus.d_we;
                        bus.mem_wdata <= bus.d_wdata;
                        bus.mem_valid <= 1'b1;
                        state         <= ACCESS;
                    end else if (bus.i_req) begin
                        grant_d       <= 1'b0;
                        last_grant_d  <= 1'b0;
                        bus.mem_addr  <= bus.i_addr;
                        bus.mem_we    <= 4'b0000;
                        bus.mem_wdata <= '0;
                        bus.mem_valid <= 1'b1;
                        state         <= ACCESS;
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                ACCESS: begin
                    if (access_done) begin
                        bus.mem_valid <= 1'b0;
                        bus.mem_we    <= 4'b0000;
                        bus.i_ack     <= !grant_d;
                        bus.d_ack     <= grant_d;
                        bus.i_rdata   <= grant_d ? 32'h0 : rsp_word;
                        bus.d_rdata   <= grant_d ? rsp_word : 32'h0;
`ifdef MEM_ARB_TIMEOUT_EN
                        bus.i_err     <= !grant_d && timed_out;
                        bus.d_err     <= grant_d && timed_out;
`endif
                        state         <= RESP;
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
`endif
                end
                RESP: begin
                    bus.i_ack   <= 1'b0;
                    bus.d_ack   <= 1'b0;
                    bus.i_rdata <= '0;
                    bus.d_rdata <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
                    bus.i_err   <= 1'b0;
                    bus.d_err   <= 1'b0;
`endif
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table of single-requester accesses plus hand sequences for
// round-robin conflicts, reset during an access and the ACCESS timeout.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if bus ();

    mem_arbiter #(.TIMEOUT(8)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Memory model: asserts mem_ready after mem_waits wait cycles of mem_valid.
    int          mem_waits = 0;
    logic [31:0] mem_word  = 32'h0;
    int          wait_cnt  = 0;

    always @(negedge clk) begin
        if (bus.mem_valid) begin
            if (wait_cnt >= mem_waits) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = mem_word;
                wait_cnt      = 0;
            end else begin
                bus.mem_ready = 1'b0;
                bus.mem_rdata = 32'hBADBAD00;
                wait_cnt      = wait_cnt + 1;
            end
        end else begin
            bus.mem_ready = 1'b0;
            bus.mem_rdata = 32'hBADBAD11;
            wait_cnt      = 0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    typedef struct {
        bit          is_d;
        logic [3:0]  we;
        logic [29:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] word;
        logic [3:0]  exp_we;
        int          exp_lat;
        bit          chk_rdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [7];
    int   order [6];

    task automatic run_vec(input vec_t v, input string nm);
        bit got   = 0;
        bit first = 1;
        int vcyc  = 0;
        mem_waits   = v.waits;
        mem_word    = v.word;
        bus.d_we    = v.we;
        bus.d_addr  = v.addr;
        bus.d_wdata = v.wdata;
        bus.i_addr  = v.addr;
        if (v.is_d) bus.d_req = 1'b1;
        else        bus.i_req = 1'b1;
        for (int c = 1; c <= 60 && !got; c++) begin
            @(negedge clk);
            if (bus.mem_valid) begin
                vcyc = vcyc + 1;
                if (first) begin
                    chk({nm, "_mem_addr"}, 32'(bus.mem_addr), 32'(v.addr));
                    chk({nm, "_mem_we"}, 32'(bus.mem_we), 32'(v.exp_we));
                    if (v.is_d) chk({nm, "_mem_wdata"}, bus.mem_wdata, v.wdata);
                    first = 0;
                end else begin
                    chk({nm, "_mem_stable"}, {bus.mem_addr, 2'b00} ^ 32'(bus.mem_we),
                        {v.addr, 2'b00} ^ 32'(v.exp_we));
                end
            end
            if (bus.i_ack || bus.d_ack) begin
                got = 1;
                chk({nm, "_latency"}, 32'(c), 32'(v.exp_lat));
                chk({nm, "_ack_port"}, {31'b0, bus.d_ack} | {30'b0, bus.i_ack, 1'b0},
                    v.is_d ? 32'h1 : 32'h2);
                if (v.chk_rdata)
                    chk({nm, "_rdata"}, v.is_d ? bus.d_rdata : bus.i_rdata, v.exp_rdata);
                chk({nm, "_other_rdata"}, v.is_d ? bus.i_rdata : bus.d_rdata, 32'h0);
                chk({nm, "_err"}, 32'({bus.i_err, bus.d_err}), 32'h0);
                chk({nm, "_valid_we_dropped"}, 32'({bus.mem_valid, bus.mem_we}), 32'h0);
                chk({nm, "_valid_cycles"}, 32'(vcyc), 32'(v.waits + 1));
                bus.d_req = 1'b0;
                bus.i_req = 1'b0;
            end
        end
        if (!got) chk({nm, "_ack_timeout"}, 32'h0, 32'h1);
        @(negedge clk);
        chk({nm, "_ack_one_cycle"}, 32'({bus.i_ack, bus.d_ack}) | bus.i_rdata | bus.d_rdata, 32'h0);
    endtask

    // Both sides request and reissue after each ack; records which side each ack went to.
    task automatic run_conflict(input int n_acc, input string nm);
        int n       = 0;
        int overlap = 0;
        mem_waits   = 1;
        mem_word    = 32'hCAFE0001;
        bus.i_addr  = 30'h100;
        bus.d_addr  = 30'h200;
        bus.d_we    = 4'b0000;
        bus.i_req   = 1'b1;
        bus.d_req   = 1'b1;
        for (int c = 0; c < 300 && n < n_acc; c++) begin
            @(negedge clk);
            if ((bus.i_ack && bus.d_ack) || (bus.mem_valid && (bus.i_ack || bus.d_ack)))
                overlap = overlap + 1;
            if (bus.d_ack) begin
                chk($sformatf("%s_d_rdata%0d", nm, n), bus.d_rdata, 32'hCAFE0001);
                if (n < 6) order[n] = 1;
                n = n + 1;
                bus.d_req = 1'b0;
            end else begin
                bus.d_req = 1'b1;
            end
            if (bus.i_ack) begin
                chk($sformatf("%s_i_rdata%0d", nm, n), bus.i_rdata, 32'hCAFE0001);
                if (n < 6) order[n] = 0;
                n = n + 1;
                bus.i_req = 1'b0;
            end else begin
                bus.i_req = 1'b1;
            end
        end
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        chk({nm, "_count"}, 32'(n), 32'(n_acc));
        chk({nm, "_overlap"}, 32'(overlap), 32'h0);
        for (int k = 0; k < n_acc && k < 6; k++)
            chk($sformatf("%s_grant%0d", nm, k), 32'(order[k]), (k % 2 == 0) ? 32'h1 : 32'h0);
        repeat (3) @(negedge clk);
        chk({nm, "_idle_after"}, 32'({bus.mem_valid, bus.i_ack, bus.d_ack}), 32'h0);
    endtask

    initial begin
        int   bad;
        bit   got;
        vec_t post;

        vecs[0] = '{0, 4'hF, 30'h4,        32'h0,        0, 32'hDEADBEEF, 4'h0, 2, 1, 32'hDEADBEEF};
        vecs[1] = '{1, 4'hC, 30'h10,       32'hBEEF0000, 3, 32'h12345678, 4'hC, 5, 0, 32'h0};
        vecs[2] = '{1, 4'h0, 30'h3FFFFFFF, 32'hFFFFFFFF, 1, 32'h0F0F0F0F, 4'h0, 3, 1, 32'h0F0F0F0F};
        vecs[3] = '{0, 4'h0, 30'h0,        32'h0,        2, 32'h80000001, 4'h0, 4, 1, 32'h80000001};
        vecs[4] = '{1, 4'hF, 30'h2AAAAAAA, 32'h5555AAAA, 0, 32'h0,        4'hF, 2, 0, 32'h0};
        vecs[5] = '{1, 4'h1, 30'h1,        32'h000000FF, 0, 32'hFFFFFFFF, 4'h1, 2, 0, 32'h0};
        vecs[6] = '{0, 4'h0, 30'h3FFFFFFF, 32'h0,        5, 32'h0000FFFF, 4'h0, 7, 1, 32'h0000FFFF};
        post    = '{1, 4'h0, 30'h77,       32'h0,        0, 32'h600DF00D, 4'h0, 2, 1, 32'h600DF00D};

        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = '0; bus.d_addr = '0; bus.d_wdata = '0;

        repeat (3) @(negedge clk);
        chk("rst_i_ack", 32'(bus.i_ack), 32'h0);
        chk("rst_d_ack", 32'(bus.d_ack), 32'h0);
        chk("rst_i_rdata", bus.i_rdata, 32'h0);
        chk("rst_d_rdata", bus.d_rdata, 32'h0);
        chk("rst_errs", 32'({bus.i_err, bus.d_err}), 32'h0);
        chk("rst_mem_valid", 32'(bus.mem_valid), 32'h0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        resetn = 1'b1;

        run_conflict(6, "rr");

        for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Reset while the memory is stalling an access.
        mem_waits   = 50;
        mem_word    = 32'h11111111;
        bus.d_we    = 4'b0011;
        bus.d_addr  = 30'h55;
        bus.d_wdata = 32'hA5A5A5A5;
        bus.d_req   = 1'b1;
        got = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (bus.mem_valid) got = 1;
        end
        chk("mid_rst_access_seen", 32'(got), 32'h1);
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("mid_rst_valid_async", 32'(bus.mem_valid), 32'h0);
        chk("mid_rst_we_async", 32'(bus.mem_we), 32'h0);
        chk("mid_rst_ack_async", 32'({bus.i_ack, bus.d_ack}), 32'h0);
        bus.d_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.mem_valid || bus.i_ack || bus.d_ack) bad = bad + 1;
        end
        chk("mid_rst_idle_after", 32'(bad), 32'h0);
        run_conflict(2, "post_rst_rr");
        run_vec(post, "post_rst_d");

        // Memory that never answers.
        mem_waits   = 1000;
        mem_word    = 32'h77777777;
        bus.d_we    = 4'b0000;
        bus.d_addr  = 30'h66;
        bus.d_req   = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
        got = 0;
        for (int c = 1; c <= 40 && !got; c++) begin
            @(negedge clk);
            if (bus.d_ack || bus.i_ack) begin
                got = 1;
                chk("to_latency", 32'(c), 32'd9);
                chk("to_d_ack", 32'(bus.d_ack), 32'h1);
                chk("to_d_err", 32'(bus.d_err), 32'h1);
                chk("to_d_rdata", bus.d_rdata, 32'h0);
                chk("to_i_side", 32'({bus.i_ack, bus.i_err}), 32'h0);
                chk("to_valid_dropped", 32'(bus.mem_valid), 32'h0);
                bus.d_req = 1'b0;
            end
        end
        if (!got) chk("to_ack_seen", 32'h0, 32'h1);
        @(negedge clk);
        chk("to_err_one_cycle", 32'({bus.d_ack, bus.d_err}), 32'h0);
`else
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus.d_ack || bus.i_ack || bus.d_err || bus.i_err) bad = bad + 1;
        end
        chk("nto_no_ack", 32'(bad), 32'h0);
        chk("nto_still_valid", 32'(bus.mem_valid), 32'h1);
        bus.d_req = 1'b0;
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
